// File: rtl/wfg_wb_master_if.sv
// Command/response stream plus Wishbone master bus bundle.
// master: the bridge side; slave: the command source, response sink and Wishbone slave side.
interface wfg_wb_master_if #(
  parameter int BUSW = 32
);
  logic            cmd_tvalid;
  logic            cmd_tready;
  logic            cmd_we;
  logic [BUSW-1:0] cmd_addr;
  logic [BUSW-1:0] cmd_data;

  logic            rsp_tvalid;
  logic            rsp_tready;
  logic [BUSW-1:0] rsp_data;
  logic            rsp_err;

  logic            wbm_cyc_o;
  logic            wbm_stb_o;
  logic            wbm_we_o;
  logic [3:0]      wbm_sel_o;
  logic [BUSW-1:0] wbm_adr_o;
  logic [BUSW-1:0] wbm_dat_o;
  logic            wbm_ack_i;
  logic [BUSW-1:0] wbm_dat_i;

  modport master (
    input  cmd_tvalid, cmd_we, cmd_addr, cmd_data,
    output cmd_tready,
    output rsp_tvalid, rsp_data, rsp_err,
    input  rsp_tready,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o,
    output wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_ack_i, wbm_dat_i
  );

  modport slave (
    output cmd_tvalid, cmd_we, cmd_addr, cmd_data,
    input  cmd_tready,
    input  rsp_tvalid, rsp_data, rsp_err,
    output rsp_tready,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o,
    input  wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_ack_i, wbm_dat_i
  );
endinterface

// File: rtl/wfg_wb_master.sv
// Command-stream to Wishbone master bridge, one transaction at a time.
// Ports: wb_clk_i, wb_rst_n_i (async, active-low), bus (wfg_wb_master_if.master).
module wfg_wb_master #(
  parameter int BUSW    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n_i,
  wfg_wb_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Last wait-count value before the strobe is abandoned.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t          state_q;
  logic [15:0]     cnt_q;
  logic            cmd_tready_q;
  logic            rsp_tvalid_q;
  logic [BUSW-1:0] rsp_data_q;
  logic            rsp_err_q;
  logic            cyc_q;
  logic            we_q;
  logic [BUSW-1:0] adr_q;
  logic [BUSW-1:0] dat_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cmd_tready_q <= 1'b1;
      rsp_tvalid_q <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.cmd_tvalid) begin
            state_q      <= BUS;
            cnt_q        <= '0;
            cmd_tready_q <= 1'b0;
            cyc_q        <= 1'b1;
            we_q         <= bus.cmd_we;
            adr_q        <= bus.cmd_addr;
            dat_q        <= bus.cmd_we ? bus.cmd_data : '0;
          end
        end
        BUS: begin
          // Ack is checked first so it wins over a same-cycle timeout.
          if (bus.wbm_ack_i) begin
            state_q      <= RESP;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            rsp_tvalid_q <= 1'b1;
            rsp_data_q   <= we_q ? '0 : bus.wbm_dat_i;
            rsp_err_q    <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q      <= RESP;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            rsp_tvalid_q <= 1'b1;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RESP: begin
          if (bus.rsp_tready) begin
            state_q      <= IDLE;
            rsp_tvalid_q <= 1'b0;
            cmd_tready_q <= 1'b1;
          end
        end
        default: begin
          state_q      <= IDLE;
          cmd_tready_q <= 1'b1;
          rsp_tvalid_q <= 1'b0;
          cyc_q        <= 1'b0;
          we_q         <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_tready = cmd_tready_q;
  assign bus.rsp_tvalid = rsp_tvalid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.wbm_cyc_o  = cyc_q;
  assign bus.wbm_stb_o  = cyc_q;
  assign bus.wbm_we_o   = we_q;
  assign bus.wbm_sel_o  = 4'b1111;
  assign bus.wbm_adr_o  = adr_q;
  assign bus.wbm_dat_o  = dat_q;

endmodule
